ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB-Lite responder wrapping a word-organised on-chip SRAM. It is the target end of transfers issued by AHB masters, including the DMA engine: it serves single and burst beats, and supports byte, halfword and word accesses with configurable wait states. It returns a two-cycle ERROR response for out-of-range, misaligned or oversize accesses. It sits on the system AHB behind the address decoder, which drives HSEL.

Parameters:
ADDR_WIDTH, 32, width of HADDR
DATA_WIDTH, 32, bus/data width; fixed at 32 for this block
BASE_ADDR, 32'h0030_0000, byte address of memory word 0
MEM_WORDS, 1024, depth in 32-bit words; the window is BASE_ADDR .. BASE_ADDR+4*MEM_WORDS-1
WAIT_STATES, 0, HREADYOUT-low cycles inserted in every valid data phase; legal range 0-7

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, asynchronous, active-low
HSEL  in  1  slave select from the decoder
HADDR  in  ADDR_WIDTH  byte address (address phase)
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  0 byte, 1 halfword, 2 word
HBURST  in  3  accepted and ignored; every beat is treated independently
HWDATA  in  DATA_WIDTH  write data (data phase)
HREADY  in  1  bus-level ready (mux output)
HREADYOUT  out  1  slave ready
HRESP  out  1  0 OKAY, 1 ERROR
HRDATA  out  DATA_WIDTH  read data

Behaviour:
- Transfer acceptance: a transfer is accepted at a rising edge where HSEL && HTRANS[1] && HREADY.
  - On acceptance, latch the address offset, HWRITE and HSIZE.
  - Compute valid = (HADDR-BASE_ADDR) < 4*MEM_WORDS && HSIZE<=2 && aligned.
  - Aligned means: size 1 requires addr[0]==0; size 2 requires addr[1:0]==0.
  - Addresses below BASE_ADDR are out of range. The subtraction is unsigned, so underflow wraps to a large value and fails the range check.
- IDLE/BUSY beats: HSEL with HTRANS IDLE or BUSY gives a zero-wait OKAY response with no memory access.
- Address sampling during waits: while HREADY is low, address-phase inputs are not sampled.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0.
    - Valid accept with WAIT_STATES>0 -> WAIT, with the counter loaded with WAIT_STATES.
    - Valid accept with WAIT_STATES==0 -> stay in IDLE; the data phase completes in the next cycle.
    - Invalid accept -> ERR1.
  - WAIT: HREADYOUT=0. The counter decrements each cycle; on reaching 1, go to IDLE. The data phase therefore lasts exactly WAIT_STATES+1 cycles.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 -> IDLE. A new transfer may be accepted in ERR2 and is processed normally.
- Writes:
  - Memory is updated at the edge that ends the data phase (the cycle where HREADYOUT=1), using HWDATA.
  - Byte enables are little-endian:
    - byte: lane addr[1:0]
    - halfword: lanes {addr[1],0} and {addr[1],1}
    - word: all four lanes
  - Errored writes never modify memory.
- Reads:
  - The memory word is read at the acceptance edge into the HRDATA register, so HRDATA is valid throughout the data phase and held during wait states.
  - The full word is returned regardless of HSIZE; the master selects the lanes.
  - HRDATA changes only on a valid read acceptance. Otherwise it holds its last value, including through writes and errors.
- Read-after-write hazard: a read accepted in the same cycle that completes a write to the same word must return the merged data. Bytes enabled by the write are forwarded from HWDATA; the remaining bytes come from memory.
- Reset:
  - Asserting HRESETn low forces HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE and wait counter 0, and clears the latched transfer.
  - A pending write in progress at reset is dropped.
  - Memory contents are not reset.

Test Plan:
- Word write then read: write 0xDEADBEEF to BASE_ADDR+0x10, then read the same address with WAIT_STATES=0 -> HRDATA=0xDEADBEEF in the read data phase, HREADYOUT=1 throughout, HRESP=0.
- Byte and halfword lanes: write word 0x11223344 to +0x20, then byte 0xAA to +0x21, then halfword 0xBBCC to +0x22; read +0x20 -> 0xBBCCAA44.
- Back-to-back RAW: NONSEQ write 0x12345678 to +0x30 immediately followed by NONSEQ read of +0x30 (the old contents there were 0) -> read returns 0x12345678. Repeat with a byte write of 0xFF to +0x31 -> read returns 0x1234FF78.
- Wait states: with WAIT_STATES=3, each valid transfer shows HREADYOUT low for exactly 3 cycles, then high for 1 cycle; HRDATA is stable across the whole data phase.
- Errors: each of the following gives HRESP=1 for two cycles, HREADYOUT 0 then 1, and memory unchanged on readback:
  - a write to BASE_ADDR+4*MEM_WORDS
  - a write to BASE_ADDR-4
  - a halfword write at +0x1
  - a write with HSIZE=3
  - A following valid transfer accepted in ERR2 completes OKAY.
- Reset mid-wait: with WAIT_STATES=5, pulse HRESETn low during a write data phase -> HREADYOUT=1 and HRESP=0 immediately; the target word is unchanged; the next transfer behaves normally.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite responder in front of a word-organised on-chip SRAM
// Valid beats take WAIT_STATES+1 data-phase cycles; bad beats get a two-cycle ERROR response.
module ahb_sram_slave #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0030_0000,
   parameter int                    MEM_WORDS   = 1024,
   parameter int                    WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA
);

   localparam int                    IDX_W     = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(4 * MEM_WORDS);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t                state;
   logic [2:0]            wait_cnt;
   logic                  dp_wr_pend;
   logic [IDX_W-1:0]      dp_idx;
   logic [3:0]            dp_be;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   logic [ADDR_WIDTH-1:0] offset;
   logic [IDX_W-1:0]      acc_idx;
   logic                  aligned;
   logic                  acc_valid;
   logic                  accept;
   logic [3:0]            acc_be;
   logic                  wr_commit;
   logic [DATA_WIDTH-1:0] rd_merged;
   logic                  unused_bits;

   // Unsigned subtraction: addresses below BASE_ADDR wrap high and fail the range check.
   assign offset    = HADDR - BASE_ADDR;
   assign acc_idx   = offset[IDX_W+1:2];
   assign accept    = HSEL && HTRANS[1] && HREADY;
   assign acc_valid = (offset < WIN_BYTES) && (HSIZE <= 3'd2) && aligned;
   assign wr_commit = dp_wr_pend && (state == ST_IDLE);

   assign unused_bits = ^{HBURST, HTRANS[0], offset[1:0]};

   always_comb begin
      aligned = 1'b1;
      acc_be  = 4'b1111;
      case (HSIZE)
         3'd0: acc_be = 4'b0001 << HADDR[1:0];
         3'd1: begin
            aligned = ~HADDR[0];
            acc_be  = HADDR[1] ? 4'b1100 : 4'b0011;
         end
         3'd2: aligned = (HADDR[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
   end

   // A read accepted on the edge that retires a write to the same word sees the new lanes.
   always_comb begin
      rd_merged = mem[acc_idx];
      if (wr_commit && (dp_idx == acc_idx)) begin
         for (int i = 0; i < 4; i++) begin
            if (dp_be[i]) rd_merged[8*i +: 8] = HWDATA[8*i +: 8];
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= ST_IDLE;
         wait_cnt   <= 3'd0;
         dp_wr_pend <= 1'b0;
         dp_idx     <= '0;
         dp_be      <= 4'b0000;
         HREADYOUT  <= 1'b1;
         HRESP      <= 1'b0;
         HRDATA     <= '0;
      end else begin
         if (wr_commit) dp_wr_pend <= 1'b0;
         case (state)
            ST_IDLE, ST_ERR2: begin
               state     <= ST_IDLE;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b0;
               if (accept) begin
                  if (!acc_valid) begin
                     state     <= ST_ERR1;
                     HREADYOUT <= 1'b0;
                     HRESP     <= 1'b1;
                  end else begin
                     dp_wr_pend <= HWRITE;
                     dp_idx     <= acc_idx;
                     dp_be      <= acc_be;
                     if (!HWRITE) HRDATA <= rd_merged;
                     if (WAIT_STATES > 0) begin
                        state     <= ST_WAIT;
                        wait_cnt  <= 3'(WAIT_STATES);
                        HREADYOUT <= 1'b0;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt <= 3'd1) begin
                  state     <= ST_IDLE;
                  wait_cnt  <= 3'd0;
                  HREADYOUT <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            ST_ERR1: begin
               state     <= ST_ERR2;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (wr_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (dp_be[i]) mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed bench for ahb_sram_slave
// Three instances (0, 3 and 5 wait states) share one bus; only the selected one sees HSEL.
module tb_ahb_sram_slave;

   localparam logic [31:0] BASE = 32'h0030_0000;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] hwdata;
   int          inst;

   logic        ro0, ro1, ro2;
   logic        rs0, rs1, rs2;
   logic [31:0] rd0, rd1, rd2;
   logic        cur_ready, cur_resp;
   logic [31:0] cur_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 HCLK = ~HCLK;

   ahb_sram_slave #(.WAIT_STATES(0)) u_ws0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel && inst == 0), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HWDATA(hwdata), .HREADY(ro0), .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0));

   ahb_sram_slave #(.WAIT_STATES(3)) u_ws3 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel && inst == 1), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HWDATA(hwdata), .HREADY(ro1), .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1));

   ahb_sram_slave #(.WAIT_STATES(5)) u_ws5 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel && inst == 2), .HADDR(haddr),
      .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
      .HWDATA(hwdata), .HREADY(ro2), .HREADYOUT(ro2), .HRESP(rs2), .HRDATA(rd2));

   always_comb begin
      cur_ready = ro0;
      cur_resp  = rs0;
      cur_rdata = rd0;
      case (inst)
         1: begin cur_ready = ro1; cur_resp = rs1; cur_rdata = rd1; end
         2: begin cur_ready = ro2; cur_resp = rs2; cur_rdata = rd2; end
         default: ;
      endcase
   end

   typedef struct {
      int          k;
      logic        wr;
      logic [31:0] off;
      logic [2:0]  sz;
      logic [31:0] wd;
      logic        err;
      logic        chk;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic addr_phase(input int k, input logic wr, input logic [31:0] off, input logic [2:0] sz);
      inst   = k;
      hsel   = 1'b1;
      htrans = 2'b10;
      haddr  = BASE + off;
      hwrite = wr;
      hsize  = sz;
   endtask

   task automatic go_idle();
      hsel   = 1'b0;
      htrans = 2'b00;
   endtask

   task automatic xfer(input int k, input logic wr, input logic [31:0] off, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output int nw,
                       output logic r1, output logic rl, output logic stable);
      @(negedge HCLK);
      addr_phase(k, wr, off, sz);
      @(negedge HCLK);
      go_idle();
      hwdata = wd;
      nw     = 0;
      r1     = cur_resp;
      rd     = cur_rdata;
      stable = 1'b1;
      while (!cur_ready && nw < 20) begin
         nw++;
         @(negedge HCLK);
         if (cur_rdata !== rd) stable = 1'b0;
      end
      rl = cur_resp;
   endtask

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 3 : 5;
   endfunction

   initial begin
      logic [31:0] rd;
      int          nw;
      logic        r1, rl, st;

      // k, wr, off, size, wdata, err, chk, expected rdata
      vecs.push_back('{0, 1'b1, 32'h10,       3'd2, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{0, 1'b0, 32'h10,       3'd2, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF});
      vecs.push_back('{0, 1'b1, 32'h20,       3'd2, 32'h11223344, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{0, 1'b1, 32'h21,       3'd0, 32'hFFFFAAFF, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{0, 1'b1, 32'h22,       3'd1, 32'hBBCC5566, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{0, 1'b0, 32'h20,       3'd2, 32'h0,        1'b0, 1'b1, 32'hBBCCAA44});
      vecs.push_back('{0, 1'b0, 32'h23,       3'd0, 32'h0,        1'b0, 1'b1, 32'hBBCCAA44});
      vecs.push_back('{0, 1'b1, 32'h0,        3'd2, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{0, 1'b1, 32'hFFC,      3'd2, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{0, 1'b0, 32'hFFC,      3'd2, 32'h0,        1'b0, 1'b1, 32'h0F0F0F0F});
      vecs.push_back('{0, 1'b1, 32'h1000,     3'd2, 32'hBAD0BAD0, 1'b1, 1'b0, 32'h0});
      vecs.push_back('{0, 1'b1, 32'hFFFFFFFC, 3'd2, 32'hBAD1BAD1, 1'b1, 1'b0, 32'h0});
      vecs.push_back('{0, 1'b1, 32'h1,        3'd1, 32'hBAD2BAD2, 1'b1, 1'b0, 32'h0});
      vecs.push_back('{0, 1'b1, 32'h0,        3'd3, 32'hBAD3BAD3, 1'b1, 1'b0, 32'h0});
      vecs.push_back('{0, 1'b0, 32'h2,        3'd2, 32'h0,        1'b1, 1'b1, 32'h0F0F0F0F});
      vecs.push_back('{0, 1'b0, 32'h0,        3'd2, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D});
      vecs.push_back('{0, 1'b0, 32'hFFC,      3'd2, 32'h0,        1'b0, 1'b1, 32'h0F0F0F0F});
      vecs.push_back('{0, 1'b0, 32'h10,       3'd2, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF});
      vecs.push_back('{1, 1'b1, 32'h40,       3'd2, 32'hA5A55A5A, 1'b0, 1'b0, 32'h0});
      vecs.push_back('{1, 1'b0, 32'h40,       3'd2, 32'h0,        1'b0, 1'b1, 32'hA5A55A5A});
      vecs.push_back('{1, 1'b1, 32'h43,       3'd1, 32'h00000000, 1'b1, 1'b0, 32'h0});
      vecs.push_back('{1, 1'b0, 32'h41,       3'd0, 32'h0,        1'b0, 1'b1, 32'hA5A55A5A});

      HRESETn = 1'b0;
      inst    = 0;
      hsel    = 1'b0;
      haddr   = '0;
      htrans  = 2'b00;
      hwrite  = 1'b0;
      hsize   = 3'd2;
      hburst  = 3'b001;
      hwdata  = '0;
      repeat (3) @(negedge HCLK);
      check("reset hreadyout", {31'd0, ro0 & ro1 & ro2}, 32'd1);
      check("reset hresp", {31'd0, rs0 | rs1 | rs2}, 32'd0);
      check("reset hrdata", rd0 | rd1 | rd2, 32'd0);
      HRESETn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         xfer(vecs[i].k, vecs[i].wr, vecs[i].off, vecs[i].sz, vecs[i].wd, rd, nw, r1, rl, st);
         check($sformatf("v%0d waits", i), nw, vecs[i].err ? 1 : ws_of(vecs[i].k));
         check($sformatf("v%0d first resp", i), {31'd0, r1}, {31'd0, vecs[i].err});
         check($sformatf("v%0d last resp", i), {31'd0, rl}, {31'd0, vecs[i].err});
         check($sformatf("v%0d rdata stable", i), {31'd0, st}, 32'd1);
         if (vecs[i].chk) check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
      end

      // Back-to-back write then read of the same word.
      xfer(0, 1'b1, 32'h30, 3'd2, 32'h0, rd, nw, r1, rl, st);
      @(negedge HCLK);
      addr_phase(0, 1'b1, 32'h30, 3'd2);
      @(negedge HCLK);
      check("raw1 write ready", {31'd0, cur_ready}, 32'd1);
      hwdata = 32'h12345678;
      addr_phase(0, 1'b0, 32'h30, 3'd2);
      @(negedge HCLK);
      go_idle();
      check("raw1 read ready", {31'd0, cur_ready}, 32'd1);
      check("raw1 read resp", {31'd0, cur_resp}, 32'd0);
      check("raw1 rdata", cur_rdata, 32'h12345678);
      @(negedge HCLK);
      addr_phase(0, 1'b1, 32'h31, 3'd0);
      @(negedge HCLK);
      hwdata = 32'hAAAAFFAA;
      addr_phase(0, 1'b0, 32'h30, 3'd2);
      @(negedge HCLK);
      go_idle();
      check("raw2 rdata", cur_rdata, 32'h1234FF78);
      xfer(0, 1'b0, 32'h30, 3'd2, 32'h0, rd, nw, r1, rl, st);
      check("raw2 readback", rd, 32'h1234FF78);

      // Error response with the next transfer accepted during its second cycle.
      @(negedge HCLK);
      addr_phase(0, 1'b1, 32'h10, 3'd3);
      @(negedge HCLK);
      check("err1 ready", {31'd0, cur_ready}, 32'd0);
      check("err1 resp", {31'd0, cur_resp}, 32'd1);
      hwdata = 32'h55555555;
      addr_phase(0, 1'b0, 32'h10, 3'd2);
      @(negedge HCLK);
      check("err2 ready", {31'd0, cur_ready}, 32'd1);
      check("err2 resp", {31'd0, cur_resp}, 32'd1);
      @(negedge HCLK);
      go_idle();
      check("after err ready", {31'd0, cur_ready}, 32'd1);
      check("after err resp", {31'd0, cur_resp}, 32'd0);
      check("after err rdata", cur_rdata, 32'hDEADBEEF);

      // Reset in the middle of a wait-stated write.
      xfer(2, 1'b1, 32'h50, 3'd2, 32'h11111111, rd, nw, r1, rl, st);
      @(negedge HCLK);
      addr_phase(2, 1'b1, 32'h50, 3'd2);
      @(negedge HCLK);
      go_idle();
      hwdata = 32'h99999999;
      check("midwait ready low", {31'd0, cur_ready}, 32'd0);
      repeat (2) @(negedge HCLK);
      check("midwait still low", {31'd0, cur_ready}, 32'd0);
      #2 HRESETn = 1'b0;
      #1;
      check("rst async ready", {31'd0, cur_ready}, 32'd1);
      check("rst async resp", {31'd0, cur_resp}, 32'd0);
      check("rst async rdata", cur_rdata, 32'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      xfer(2, 1'b0, 32'h50, 3'd2, 32'h0, rd, nw, r1, rl, st);
      check("post rst read", rd, 32'h11111111);
      check("post rst waits", nw, 5);
      xfer(2, 1'b1, 32'h50, 3'd2, 32'h22222222, rd, nw, r1, rl, st);
      check("post rst write waits", nw, 5);
      xfer(2, 1'b0, 32'h50, 3'd2, 32'h0, rd, nw, r1, rl, st);
      check("post rst readback", rd, 32'h22222222);
      check("post rst resp", {31'd0, rl}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
